cfs_fifo_push_arbiter: RTL
==========================

// Module: cfs_fifo_push_arbiter
// PURPOSE
//  Round-robin arbiter that shares the push side of one cfs_synch_fifo among NUM_REQ requesters.
//  - Grants one requester at a time for a burst of up to MAX_BURST beats, then rotates priority.
//  - Sits in the push clock domain, directly in front of the FIFO push_valid/push_data/push_ready.
//  - Gives each source fair, bounded-latency access to the shared buffer.
// PARAMETERS
//  NUM_REQ     4   number of requesters, >= 2
//  DATA_WIDTH  32  beat width, must match the FIFO DATA_WIDTH
//  MAX_BURST   4   max beats per grant before forced release, >= 1
//  IDW         localparam = $clog2(NUM_REQ); BCW = $clog2(MAX_BURST+1)
// PORTS
//  clk              in   1                   push-domain clock
//  reset            in   1                   synchronous, active-high reset
//  req_valid        in   NUM_REQ             per-requester beat valid
//  req_data         in   NUM_REQ*DATA_WIDTH  requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
//  req_ready        out  NUM_REQ             per-requester beat accepted
//  fifo_push_valid  out  1                   to FIFO push_valid
//  fifo_push_data   out  DATA_WIDTH          to FIFO push_data
//  fifo_push_ready  in   1                   from FIFO push_ready (may depend on fifo_push_valid)
//  grant_active     out  1                   1 while in GRANT state
//  grant_id         out  IDW                 index of the granted requester
//  beat_cnt         out  BCW                 beats accepted in the current grant
// BEHAVIOUR
//  Clock and reset
//  - Single clock. Reset is sampled on the rising clk edge.
//  - Reset state: state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, grant_active=0.
//  - Combinational outputs during reset and in IDLE: req_ready=0, fifo_push_valid=0, fifo_push_data=0.
//  - Reset mid-burst: the burst is abandoned; IDLE is entered on the next cycle with rr_ptr=0.
//  - No beat is accepted in the cycle reset is high.
//  State machine (2 states)
//  - IDLE:
//    - winner = first i with req_valid[i]=1, scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//    - If any req_valid: grant_id<=winner, beat_cnt<=0, go to GRANT.
//    - Else stay in IDLE.
//    - Arbitration latency is 1 cycle: a request seen in IDLE cycle T can transfer no earlier than T+1.
//  - GRANT (g = grant_id):
//    - fifo_push_valid = req_valid[g]; fifo_push_data = req_data[g].
//    - req_ready[g] = fifo_push_ready; req_ready of every other requester = 0.
//    - Beat = fifo_push_valid & fifo_push_ready. On each beat, beat_cnt increments.
//    - Release when either:
//      (a) a beat occurs with beat_cnt == MAX_BURST-1, or
//      (b) req_valid[g] == 0 in any GRANT cycle.
//    - On release: rr_ptr <= (g+1) mod NUM_REQ, beat_cnt <= 0, go to IDLE.
//    - Exactly one IDLE bubble separates consecutive grants.
//  Rules
//  - No combinational path from fifo_push_ready to fifo_push_valid. This avoids a loop with the
//    FIFO push_ready = push_valid & !full.
//  - FIFO full (fifo_push_ready=0) stalls the burst: beat_cnt, grant_id and data selection hold.
//    There is no release on stall alone.
//  - Non-granted requesters must hold req_valid and data until their req_ready.
//  - Release case (b) is the only way a grant ends early; no beats are lost or duplicated.
//  - rr_ptr wraps from NUM_REQ-1 to 0. grant_id is valid only while grant_active=1.
//  - MAX_BURST=1: every accepted beat releases the grant.
// TESTING (NUM_REQ=4, DATA_WIDTH=32, MAX_BURST=4)
//  1. Reset held 3 cycles with all req_valid=1
//     -> req_ready=0, fifo_push_valid=0, grant_active=0 throughout.
//  2. Only req1 valid with 6 beats 0xA0..0xA5, ready=1
//     -> IDLE, GRANT id=1 for 0xA0-A3 (beat_cnt 0..3), IDLE, GRANT id=1 for 0xA4-A5, then IDLE.
//  3. All 4 requesters continuously valid, ready=1
//     -> grant order 0,1,2,3,0.
//     -> Each grant is 4 beats followed by 1 idle cycle (5-cycle period), rr_ptr wraps 3->0.
//  4. req2 granted, fifo_push_ready=0 for 3 cycles after beat 2
//     -> beat_cnt holds at 2, data stable, no release; burst finishes beats 3-4 once ready returns.
//  5. req0 drops req_valid after 2 beats
//     -> release, IDLE; with req0 and req3 valid, the next grant is id=1 if req1 valid, else id=3.
//  6. Reset asserted during beat 3 of a req3 burst
//     -> next cycle IDLE with rr_ptr=0; with all requesters valid, the next grant is id=0.

Source files
------------

// File: rtl/cfs_fifo_push_arbiter.sv
// Round-robin push arbiter sharing one FIFO push port among NUM_REQ sources; 1-cycle grant latency,
// bursts of up to MAX_BURST beats; FIFO full stalls the burst in place (no release on stall).
module cfs_fifo_push_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BURST  = 4,
  localparam int IDW        = $clog2(NUM_REQ),
  localparam int BCW        = $clog2(MAX_BURST + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_push_valid,
  output logic [DATA_WIDTH-1:0]         fifo_push_data,
  input  logic                          fifo_push_ready,
  output logic                          grant_active,
  output logic [IDW-1:0]                grant_id,
  output logic [BCW-1:0]                beat_cnt
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam logic [BCW-1:0] LAST_BEAT = BCW'(MAX_BURST - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_REQ - 1);

  state_t         state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0] grant_id_q, grant_id_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

  logic [IDW-1:0]        winner;
  logic [IDW-1:0]        cand;
  logic                  any_req;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  beat;

  // Scan from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    winner  = rr_ptr_q;
    cand    = '0;
    any_req = |req_valid;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDW'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        winner = cand;
      end
    end
  end

  always_comb begin
    sel_data  = '0;
    sel_valid = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == IDW'(i)) begin
        sel_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_valid = req_valid[i];
      end
    end
  end

  // fifo_push_valid depends only on grant state and req_valid, never on fifo_push_ready.
  always_comb begin
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_id_d      = grant_id_q;
    beat_cnt_d      = beat_cnt_q;
    req_ready       = '0;
    fifo_push_valid = 1'b0;
    fifo_push_data  = '0;
    beat            = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          grant_id_d = winner;
          beat_cnt_d = '0;
          state_d    = ST_GRANT;
        end
      end
      ST_GRANT: begin
        fifo_push_valid       = sel_valid;
        fifo_push_data        = sel_data;
        req_ready[grant_id_q] = fifo_push_ready;
        beat                  = sel_valid & fifo_push_ready;
        if (!sel_valid || (beat && (beat_cnt_q == LAST_BEAT))) begin
          rr_ptr_d   = (grant_id_q == LAST_ID) ? '0 : grant_id_q + IDW'(1);
          beat_cnt_d = '0;
          state_d    = ST_IDLE;
        end else if (beat) begin
          beat_cnt_d = beat_cnt_q + BCW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (reset) begin
      req_ready       = '0;
      fifo_push_valid = 1'b0;
      fifo_push_data  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign grant_active = (state_q == ST_GRANT);
  assign grant_id     = grant_id_q;
  assign beat_cnt     = beat_cnt_q;

endmodule
